vector_mem_bridge: RTL and testbench
====================================

# vector_mem_bridge

Sequential bridge between the vector CPU's data-memory port and a byte-wide synchronous data RAM. A single vector store (R lanes × N bits) is split into R single-lane RAM writes, and a vector load is built up from R single-lane RAM reads. While a transfer is in progress, the bridge holds the CPU through `Busy`, which the top level ties to the CPU `pause` input. It sits directly downstream of the CPU's `Address`/`WriteData`/`MemWriteM` outputs and drives its `ReadData` input.

## Interface
- I, 32, CPU address width
- N, 8, lane width in bits (equals RAM data width)
- R, 6, number of lanes per vector
- A, 16, RAM address width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- MemWrite  in  1  vector store request (CPU `MemWriteM`)
- MemRead  in  1  vector load request
- Address  in  I  base byte address of lane 0
- WriteData  in  R×N  store data, lane k = WriteData[k]
- ReadData  out  R×N  assembled load data, registered
- ReadValid  out  1  one-cycle pulse: ReadData updated
- Busy  out  1  transfer in progress, registered
- RamAddr  out  A  RAM address
- RamWData  out  N  RAM write data
- RamWe  out  1  RAM write enable
- RamRData  in  N  RAM read data, valid one cycle after RamAddr is presented

## Operation
- Reset values: all outputs are 0; state is IDLE; lane counter is 0.
- States and transitions:
  - IDLE → WR when `MemWrite` is high.
  - IDLE → RD when `MemRead` is high and `MemWrite` is low.
  - Requests are sampled only in IDLE. Requests that arrive in any other state are ignored.
- Priority: if `MemWrite` and `MemRead` are high together, the write wins and the read is dropped.
- Acceptance latches the base address as `Address[A-1:0]` (upper bits discarded). A store also latches all R lanes of `WriteData`.
- WR state, lane k = 0..R-1:
  - RamWe = 1, RamAddr = base+k, RamWData = latched lane k.
  - WR → IDLE after lane R-1.
- RD state, lane k = 0..R-1:
  - RamWe = 0, RamAddr = base+k.
  - Lane k-1 is captured from RamRData.
  - RD → RD_LAST after lane R-1.
- RD_LAST: capture lane R-1, then → IDLE. ReadValid pulses high in the following cycle.
- Address arithmetic is modulo 2^A: base+k wraps from 2^A−1 to 0 with no error.
- Only lanes of a completed read update ReadData. ReadData holds its value across stores and across idle cycles.
- `Busy` = 1 in WR, RD and RD_LAST; 0 in IDLE.
- Reset asserted mid-transfer aborts immediately:
  - RamWe drops asynchronously.
  - Partially written lanes stay in the RAM.
  - No ReadValid pulse is produced.
- In IDLE: RamWe = 0, and RamAddr/RamWData hold their last values.

## Timing
- Cycle 0 is the request cycle; the request is sampled at the end of cycle 0.
- Store: RamWe is high in cycles 1..R, Busy is high in cycles 1..R, back in IDLE at cycle R+1. Total R cycles.
- Load: RamAddr steps through cycles 1..R, RD_LAST is cycle R+1, Busy is high in cycles 1..R+1, ReadValid is high in cycle R+2. With R=6, ReadValid is in cycle 8.
- A request present in the first IDLE cycle after completion is accepted, so back-to-back requests leave no gap beyond that cycle.
- Busy is registered, so the CPU sees it one cycle after acceptance. The CPU must not change `Address`/`WriteData` during cycle 0. The bridge latches both, so changes after cycle 0 are harmless.

## Structure
- Package `vmem_pkg`:
  - state enum `vmem_state_t` {IDLE, WR, RD, RD_LAST}
  - default parameter constants
  - lane-counter width, computed with $clog2(R)
- One sub-module is natural: `vmem_lane_mux`, a combinational R:1 lane selector for RamWData. Lane capture for ReadData and the FSM stay in the top module.

## Test plan
- Store, base 0x0010, lanes 0x11..0x66 → RamWe high for 6 cycles, addresses 0x10..0x15 with matching data, Busy high in cycles 1–6.
- Load after that store, base 0x0010 → ReadData = {0x66,…,0x11} (lane 0 = 0x11), ReadValid in cycle 8 only, Busy high in cycles 1–7.
- Address 0x1_FFFE (A=16) load → RAM addresses 0xFFFE, 0xFFFF, 0x0000..0x0003.
- MemWrite and MemRead high together in IDLE → store executes, no ReadValid, ReadData unchanged. A request raised while Busy is ignored.
- Reset asserted in cycle 3 of a store → RamWe drops immediately, Busy=0, state IDLE. Only lanes 0–1 are present in RAM; the next load returns old data for lanes 2–5.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types and default parameters for the vector memory bridge.
package vmem_pkg;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_LAST} vmem_state_t;

    localparam int unsigned DefI = 32;
    localparam int unsigned DefN = 8;
    localparam int unsigned DefR = 6;
    localparam int unsigned DefA = 16;

    function automatic int unsigned laneCntWidth(input int unsigned r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    localparam int unsigned DefCntW = laneCntWidth(DefR);

endpackage

// File: rtl/vector_mem_bridge_if.sv
// CPU data-port and RAM-port signal bundle; master is the CPU/RAM side, slave is the bridge.
interface vector_mem_bridge_if
    import vmem_pkg::*;
#(
    parameter int unsigned I = DefI,
    parameter int unsigned N = DefN,
    parameter int unsigned R = DefR,
    parameter int unsigned A = DefA
);

    logic                  MemWrite;
    logic                  MemRead;
    logic [I-1:0]          Address;
    logic [R-1:0][N-1:0]   WriteData;
    logic [R-1:0][N-1:0]   ReadData;
    logic                  ReadValid;
    logic                  Busy;
    logic [A-1:0]          RamAddr;
    logic [N-1:0]          RamWData;
    logic                  RamWe;
    logic [N-1:0]          RamRData;

    modport master (
        output MemWrite, MemRead, Address, WriteData, RamRData,
        input  ReadData, ReadValid, Busy, RamAddr, RamWData, RamWe
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData, RamRData,
        output ReadData, ReadValid, Busy, RamAddr, RamWData, RamWe
    );

endinterface

// File: rtl/vmem_lane_mux.sv
// Combinational R:1 selector picking one N-bit lane out of a vector.
module vmem_lane_mux #(
    parameter int unsigned N    = 8,
    parameter int unsigned R    = 6,
    parameter int unsigned CntW = 3
) (
    input  logic [R-1:0][N-1:0] lanes,
    input  logic [CntW-1:0]     sel,
    output logic [N-1:0]        lane
);

    always_comb begin
        lane = '0;
        for (int k = 0; k < R; k++) begin
            if (sel == CntW'(k)) begin
                lane = lanes[k];
            end
        end
    end

endmodule

// File: rtl/vector_mem_bridge.sv
// Splits vector stores into R single-lane RAM writes and assembles vector loads
// from R single-lane RAM reads, holding the CPU via Busy meanwhile.
module vector_mem_bridge
    import vmem_pkg::*;
#(
    parameter int unsigned I = DefI,
    parameter int unsigned N = DefN,
    parameter int unsigned R = DefR,
    parameter int unsigned A = DefA
) (
    input logic                clk,
    input logic                reset,
    vector_mem_bridge_if.slave bus
);

    localparam int unsigned    CntW    = laneCntWidth(R);
    localparam logic [CntW-1:0] CntOne  = 1;
    localparam logic [CntW-1:0] CntLast = CntW'(R - 1);
    localparam logic [A-1:0]   AddrOne = 1;

    vmem_state_t             state;
    logic [CntW-1:0]         cnt;
    logic [R-1:0][N-1:0]     storeData;
    logic [R-2:0][N-1:0]     shadow;
    logic [R-1:0][N-1:0]     readData;
    logic                    readValid;
    logic                    busy;
    logic [A-1:0]            ramAddr;
    logic [N-1:0]            ramWData;
    logic                    ramWe;

    logic [R-1:0][N-1:0]     muxLanes;
    logic [CntW-1:0]         muxSel;
    logic [N-1:0]            nextLane;
    logic                    unusedAddr;

    assign unusedAddr = ^bus.Address[I-1:A];

    // In IDLE the first lane comes straight from the CPU bus; afterwards from the latched copy.
    always_comb begin
        muxLanes = storeData;
        muxSel   = cnt + CntOne;
        if (state == IDLE) begin
            muxLanes = bus.WriteData;
            muxSel   = '0;
        end
    end

    vmem_lane_mux #(
        .N    (N),
        .R    (R),
        .CntW (CntW)
    ) u_lane_mux (
        .lanes (muxLanes),
        .sel   (muxSel),
        .lane  (nextLane)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            storeData <= '0;
            shadow    <= '0;
            readData  <= '0;
            readValid <= 1'b0;
            busy      <= 1'b0;
            ramAddr   <= '0;
            ramWData  <= '0;
            ramWe     <= 1'b0;
        end else begin
            readValid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.MemWrite) begin
                        state     <= WR;
                        storeData <= bus.WriteData;
                        ramAddr   <= bus.Address[A-1:0];
                        ramWData  <= nextLane;
                        ramWe     <= 1'b1;
                        busy      <= 1'b1;
                    end else if (bus.MemRead) begin
                        state   <= RD;
                        ramAddr <= bus.Address[A-1:0];
                        busy    <= 1'b1;
                    end
                end
                WR: begin
                    if (cnt == CntLast) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ramWe <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt      <= cnt + CntOne;
                        ramAddr  <= ramAddr + AddrOne;
                        ramWData <= nextLane;
                    end
                end
                RD: begin
                    // RAM data lags the address by one cycle, so lane cnt-1 arrives now.
                    for (int k = 0; k < R - 1; k++) begin
                        if (cnt == CntW'(k + 1)) begin
                            shadow[k] <= bus.RamRData;
                        end
                    end
                    if (cnt == CntLast) begin
                        state <= RD_LAST;
                        cnt   <= '0;
                    end else begin
                        cnt     <= cnt + CntOne;
                        ramAddr <= ramAddr + AddrOne;
                    end
                end
                RD_LAST: begin
                    readData  <= {bus.RamRData, shadow};
                    readValid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ReadData  = readData;
    assign bus.ReadValid = readValid;
    assign bus.Busy      = busy;
    assign bus.RamAddr   = ramAddr;
    assign bus.RamWData  = ramWData;
    assign bus.RamWe     = ramWe;

endmodule

// File: tb/tb_vector_mem_bridge.sv
// Directed plus randomized bench for vector_mem_bridge with a behavioural RAM and reference memory.
module tb_vector_mem_bridge;

    logic clk = 1'b0;
    logic reset;
    int   nCompared = 0;
    int   nMismatch = 0;

    logic [7:0]  mem    [0:65535];
    logic [7:0]  refMem [0:65535];
    logic        loaded = 1'b0;
    logic [47:0] lastRead;

    always #5 clk = ~clk;

    vector_mem_bridge_if #(.I(32), .N(8), .R(6), .A(16)) bus ();

    vector_mem_bridge #(.I(32), .N(8), .R(6), .A(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] initByte(input int a);
        return 8'((a * 37 + 11) ^ (a >> 8));
    endfunction

    // Synchronous RAM: one-cycle read latency, preloaded on the first edge.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= initByte(i);
            loaded <= 1'b1;
        end else if (bus.RamWe) begin
            mem[bus.RamAddr] <= bus.RamWData;
        end
        bus.RamRData <= mem[bus.RamAddr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // resetAt: cycle of the store in which reset is asserted (0 = never).
    task automatic doStore(input logic [31:0] addr, input logic [47:0] data,
                           input bit alsoRead, input int resetAt);
        logic [15:0] base;
        base          = addr[15:0];
        bus.MemWrite  = 1'b1;
        bus.MemRead   = alsoRead;
        bus.Address   = addr;
        bus.WriteData = data;
        tick();
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.Address   = $urandom;
        bus.WriteData = {$urandom, $urandom};
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) bus.MemRead = 1'b0;
            if (k == resetAt) begin
                reset = 1'b1;
                #1;
                check("rst_we", bus.RamWe, 0);
                check("rst_busy", bus.Busy, 0);
                check("rst_rvalid", bus.ReadValid, 0);
                lastRead = '0;
                tick();
                reset = 1'b0;
                return;
            end
            if (k == 2) bus.MemRead = 1'b1;
            check("st_we", bus.RamWe, 1);
            check("st_addr", bus.RamAddr, 16'(base + 16'(k - 1)));
            check("st_data", bus.RamWData, data[8*(k-1) +: 8]);
            check("st_busy", bus.Busy, 1);
            check("st_rvalid", bus.ReadValid, 0);
            refMem[16'(base + 16'(k - 1))] = data[8*(k-1) +: 8];
            tick();
        end
        check("st_end_busy", bus.Busy, 0);
        check("st_end_we", bus.RamWe, 0);
        check("st_end_rvalid", bus.ReadValid, 0);
        check("st_rdata_hold", bus.ReadData, lastRead);
    endtask

    task automatic doLoad(input logic [31:0] addr);
        logic [15:0] base;
        logic [47:0] exp;
        base = addr[15:0];
        for (int j = 0; j < 6; j++) exp[8*j +: 8] = refMem[16'(base + 16'(j))];
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        bus.Address  = addr;
        tick();
        bus.MemRead = 1'b0;
        bus.Address = $urandom;
        for (int k = 1; k <= 7; k++) begin
            check("ld_busy", bus.Busy, 1);
            check("ld_rvalid", bus.ReadValid, 0);
            check("ld_we", bus.RamWe, 0);
            if (k <= 6) check("ld_addr", bus.RamAddr, 16'(base + 16'(k - 1)));
            tick();
        end
        check("ld_rvalid_pulse", bus.ReadValid, 1);
        check("ld_rdata", bus.ReadData, exp);
        check("ld_end_busy", bus.Busy, 0);
        lastRead = exp;
    endtask

    initial begin
        logic [31:0] ra;
        logic [47:0] rd;
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        lastRead      = '0;
        for (int i = 0; i < 65536; i++) refMem[i] = initByte(i);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_rdata", bus.ReadData, 0);
        check("reset_rvalid", bus.ReadValid, 0);
        check("reset_busy", bus.Busy, 0);
        check("reset_addr", bus.RamAddr, 0);
        check("reset_wdata", bus.RamWData, 0);
        check("reset_we", bus.RamWe, 0);

        doStore(32'h0000_0010, 48'h6655_4433_2211, 1'b0, 0);
        doLoad(32'h0000_0010);
        check("ld10_const", bus.ReadData, 48'h6655_4433_2211);

        doLoad(32'h0001_FFFE);

        doStore(32'h0000_0200, {$urandom, $urandom}, 1'b1, 0);
        doLoad(32'h0000_0200);

        doStore(32'h0000_0300, 48'hA5A4_A3A2_A1A0, 1'b0, 0);
        doStore(32'h0000_0300, 48'h5554_5352_5150, 1'b0, 3);
        check("rst_rdata_cleared", bus.ReadData, 0);
        doLoad(32'h0000_0300);
        check("rst_partial_const", bus.ReadData, 48'hA5A4_A3A2_5150);

        for (int n = 0; n < 12; n++) begin
            ra = $urandom;
            if (n % 3 == 0) ra[15:3] = '1;
            rd = {$urandom, $urandom};
            doStore(ra, rd, 1'(n % 4 == 1), 0);
            if ($urandom_range(0, 1) == 1) ra = $urandom;
            doLoad(ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
